// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: main MEM/WB pipe has priority, long-latency results queue in a FIFO.
// Optional macro WB_STATS_EN adds write/stall statistics counters.
module wb_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_RegWrite,
    input  logic        pipe_MemtoReg,
    input  logic [4:0]  pipe_WriteRegister,
    input  logic [31:0] pipe_ALUResult,
    input  logic [31:0] pipe_MemData,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_WriteRegister,
    input  logic [31:0] lu_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
`ifdef WB_STATS_EN
    output logic [31:0] stat_pipe_writes,
    output logic [31:0] stat_lu_writes,
    output logic [31:0] stat_lu_stall,
`endif
    output logic [31:0] lu_pending
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [4:0]    r_fifo_reg  [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_RegWrite;
    logic [4:0]    r_WriteRegister;
    logic [31:0]   r_WriteData;

    logic          w_pipe_hit;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_pending;

    assign w_pipe_hit = pipe_valid & pipe_RegWrite & (pipe_WriteRegister != 5'd0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Register-0 results complete the handshake but are never stored.
    assign w_push     = lu_valid & ~w_full & (lu_WriteRegister != 5'd0);
    assign w_pop      = ~w_pipe_hit & ~w_empty;

    assign lu_ready      = ~w_full;
    assign RegWrite      = r_RegWrite;
    assign WriteRegister = r_WriteRegister;
    assign WriteData     = r_WriteData;
    assign lu_pending    = w_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_RegWrite      <= 1'b0;
            r_WriteRegister <= '0;
            r_WriteData     <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
        end else begin
            if (w_pipe_hit) begin
                r_RegWrite      <= 1'b1;
                r_WriteRegister <= pipe_WriteRegister;
                r_WriteData     <= pipe_MemtoReg ? pipe_MemData : pipe_ALUResult;
            end else if (w_pop) begin
                r_RegWrite      <= 1'b1;
                r_WriteRegister <= r_fifo_reg[r_rptr];
                r_WriteData     <= r_fifo_data[r_rptr];
            end else begin
                r_RegWrite      <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wptr]  <= lu_WriteRegister;
            r_fifo_data[r_wptr] <= lu_data;
        end
    end

    // Only slots between read pointer and occupancy are live; stale slots are ignored.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count)
                w_pending[r_fifo_reg[r_rptr + AW'(i)]] = 1'b1;
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] r_stat_pipe;
    logic [31:0] r_stat_lu;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_pipe  <= '0;
            r_stat_lu    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pipe_hit)          r_stat_pipe  <= r_stat_pipe + 32'd1;
            if (w_pop)               r_stat_lu    <= r_stat_lu + 32'd1;
            if (lu_valid && w_full)  r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_pipe_writes = r_stat_pipe;
    assign stat_lu_writes   = r_stat_lu;
    assign stat_lu_stall    = r_stat_stall;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_wb_write_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_RegWrite, pipe_MemtoReg;
    logic [4:0]  pipe_WriteRegister;
    logic [31:0] pipe_ALUResult, pipe_MemData;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_WriteRegister;
    logic [31:0] lu_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] lu_pending;
`ifdef WB_STATS_EN
    logic [31:0] stat_pipe_writes, stat_lu_writes, stat_lu_stall;
    logic [31:0] m_sp = 0, m_sl = 0, m_ss = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_RegWrite(pipe_RegWrite), .pipe_MemtoReg(pipe_MemtoReg),
        .pipe_WriteRegister(pipe_WriteRegister), .pipe_ALUResult(pipe_ALUResult),
        .pipe_MemData(pipe_MemData),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_WriteRegister(lu_WriteRegister),
        .lu_data(lu_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
`ifdef WB_STATS_EN
        .stat_pipe_writes(stat_pipe_writes), .stat_lu_writes(stat_lu_writes),
        .stat_lu_stall(stat_lu_stall),
`endif
        .lu_pending(lu_pending)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending {reg,data}; pipe wins, otherwise oldest entry drains.
    logic [36:0] mq[$];
    logic        m_rw = 0;
    logic [4:0]  m_wr = 0;
    logic [31:0] m_wd = 0;

    always @(posedge clk) begin
        bit hit, rdy;
        logic [36:0] e;
        if (rst) begin
            mq.delete();
            m_rw = 0; m_wr = 0; m_wd = 0;
`ifdef WB_STATS_EN
            m_sp = 0; m_sl = 0; m_ss = 0;
`endif
        end else begin
            hit = pipe_valid && pipe_RegWrite && (pipe_WriteRegister != 0);
            rdy = (mq.size() < DEPTH);
`ifdef WB_STATS_EN
            if (lu_valid && !rdy) m_ss = m_ss + 1;
`endif
            if (hit) begin
                m_rw = 1; m_wr = pipe_WriteRegister;
                m_wd = pipe_MemtoReg ? pipe_MemData : pipe_ALUResult;
`ifdef WB_STATS_EN
                m_sp = m_sp + 1;
`endif
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_rw = 1; m_wr = e[36:32]; m_wd = e[31:0];
`ifdef WB_STATS_EN
                m_sl = m_sl + 1;
`endif
            end else begin
                m_rw = 0;
            end
            if (lu_valid && rdy && lu_WriteRegister != 0)
                mq.push_back({lu_WriteRegister, lu_data});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ep;
        if (chk_en) begin
            ep = 0;
            foreach (mq[k]) ep[mq[k][36:32]] = 1'b1;
            check("model RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
            if (m_rw || rst === 1'b0) begin
                check("model WriteRegister", {27'd0, WriteRegister}, {27'd0, m_wr});
                check("model WriteData", WriteData, m_wd);
            end
            check("model lu_ready", {31'd0, lu_ready}, {31'd0, (mq.size() < DEPTH)});
            check("model lu_pending", lu_pending, ep);
`ifdef WB_STATS_EN
            check("model stat_pipe", stat_pipe_writes, m_sp);
            check("model stat_lu", stat_lu_writes, m_sl);
            check("model stat_stall", stat_lu_stall, m_ss);
`endif
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle;
        pipe_valid = 0; pipe_RegWrite = 0; pipe_MemtoReg = 0; pipe_WriteRegister = 0;
        pipe_ALUResult = 0; pipe_MemData = 0;
        lu_valid = 0; lu_WriteRegister = 0; lu_data = 0;
    endtask

    task automatic pipe(input logic [4:0] r, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] mem);
        pipe_valid = 1; pipe_RegWrite = 1; pipe_MemtoReg = m2r;
        pipe_WriteRegister = r; pipe_ALUResult = alu; pipe_MemData = mem;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        check("reset RegWrite", {31'd0, RegWrite}, 32'd0);
        check("reset WriteRegister", {27'd0, WriteRegister}, 32'd0);
        check("reset WriteData", WriteData, 32'd0);
        check("reset lu_pending", lu_pending, 32'd0);
        check("reset lu_ready", {31'd0, lu_ready}, 32'd1);

        // ALU result path
        pipe(5'd5, 0, 32'h0000_1234, 32'h0);
        tick(); idle();
        check("alu RegWrite", {31'd0, RegWrite}, 32'd1);
        check("alu WriteRegister", {27'd0, WriteRegister}, 32'd5);
        check("alu WriteData", WriteData, 32'h1234);
        tick();
        check("idle RegWrite", {31'd0, RegWrite}, 32'd0);
        check("idle WriteData hold", WriteData, 32'h1234);

        // load path, then destination 0 suppressed
        pipe(5'd8, 1, 32'h11, 32'hDEAD_BEEF);
        tick();
        check("load WriteData", WriteData, 32'hDEAD_BEEF);
        check("load WriteRegister", {27'd0, WriteRegister}, 32'd8);
        pipe(5'd0, 1, 32'h11, 32'hDEAD_BEEF);
        tick(); idle();
        check("r0 RegWrite", {31'd0, RegWrite}, 32'd0);

        // single long-latency result
        lu_valid = 1; lu_WriteRegister = 5'd3; lu_data = 32'h77;
        tick(); idle();
        check("lu3 pending", lu_pending, 32'h8);
        check("lu3 no early write", {31'd0, RegWrite}, 32'd0);
        tick();
        check("lu3 RegWrite", {31'd0, RegWrite}, 32'd1);
        check("lu3 WriteRegister", {27'd0, WriteRegister}, 32'd3);
        check("lu3 WriteData", WriteData, 32'h77);
        check("lu3 pending cleared", lu_pending, 32'h0);

        // FIFO held off by a busy pipe, then drained in order
        pipe(5'd1, 0, 32'h100, 32'h0);
        lu_valid = 1; lu_WriteRegister = 5'd4; lu_data = 32'hA;
        tick();
        lu_data = 32'hB;
        tick();
        lu_valid = 0;
        check("full lu_ready", {31'd0, lu_ready}, 32'd0);
        check("full pending", lu_pending, 32'h10);
        check("full pipe WriteRegister", {27'd0, WriteRegister}, 32'd1);
        tick();
        check("starve lu_ready", {31'd0, lu_ready}, 32'd0);
        check("starve WriteData", WriteData, 32'h100);
        idle();
        tick();
        check("drainA WriteRegister", {27'd0, WriteRegister}, 32'd4);
        check("drainA WriteData", WriteData, 32'hA);
        check("drainA pending", lu_pending, 32'h10);
        tick();
        check("drainB WriteData", WriteData, 32'hB);
        check("drainB pending", lu_pending, 32'h0);
        tick();
        check("drained RegWrite", {31'd0, RegWrite}, 32'd0);

        // reset discards buffered results
        pipe(5'd2, 0, 32'h5, 32'h0);
        lu_valid = 1; lu_WriteRegister = 5'd9; lu_data = 32'h99;
        tick();
        lu_WriteRegister = 5'd10; lu_data = 32'h1010;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
        check("rst RegWrite", {31'd0, RegWrite}, 32'd0);
        check("rst lu_pending", lu_pending, 32'h0);
        check("rst lu_ready", {31'd0, lu_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst no stale write", {31'd0, RegWrite}, 32'd0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom_range(0, 199) == 0);
            pipe_valid         = $urandom_range(0, 1);
            pipe_RegWrite      = ($urandom_range(0, 3) != 0);
            pipe_MemtoReg      = $urandom_range(0, 1);
            pipe_WriteRegister = 5'($urandom_range(0, 7));
            pipe_ALUResult     = $urandom;
            pipe_MemData       = $urandom;
            lu_valid           = ($urandom_range(0, 2) != 0);
            lu_WriteRegister   = 5'($urandom_range(0, 7));
            lu_data            = $urandom;
            tick();
        end
        rst = 0;
        idle();
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
